// File: rtl/fine_gate_generator_pkg.sv
// fine_gate_generator_pkg: shared FSM encoding, slot codes and finish timing for the fine gate generator.
`timescale 1ns/1ps
package fine_gate_generator_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] HIGH   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [2:0] SLOT_P0   = 3'd0;
    localparam logic [2:0] SLOT_P45  = 3'd1;
    localparam logic [2:0] SLOT_P90  = 3'd2;
    localparam logic [2:0] SLOT_P135 = 3'd3;
    localparam logic [2:0] SLOT_N0   = 3'd4;
    localparam logic [2:0] SLOT_N45  = 3'd5;
    localparam logic [2:0] SLOT_N90  = 3'd6;
    localparam logic [2:0] SLOT_N135 = 3'd7;

    localparam int FINISH_CYCLES = 2;
endpackage

// File: rtl/fine_slot_capture.sv
// fine_slot_capture: eight flops on the eight phase edges; slot 0 samples arm on the clk edge,
// the later slots retime that copy so slot k follows the arm edge by exactly one period plus k/8.
`timescale 1ns/1ps
module fine_slot_capture
    import fine_gate_generator_pkg::*;
(
    input  logic       clk,
    input  logic       clk_p45,
    input  logic       clk_p90,
    input  logic       clk_p135,
    input  logic       reset,
    input  logic       clr,
    input  logic       arm,
    output logic [7:0] q
);
    logic s0, s1, s2, s3, s4, s5, s6, s7;

    always_ff @(posedge clk or negedge reset)
        if (!reset) s0 <= 1'b0; else s0 <= arm & ~clr;
    always_ff @(posedge clk_p45 or negedge reset)
        if (!reset) s1 <= 1'b0; else s1 <= s0 & ~clr;
    always_ff @(posedge clk_p90 or negedge reset)
        if (!reset) s2 <= 1'b0; else s2 <= s0 & ~clr;
    always_ff @(posedge clk_p135 or negedge reset)
        if (!reset) s3 <= 1'b0; else s3 <= s0 & ~clr;
    always_ff @(negedge clk or negedge reset)
        if (!reset) s4 <= 1'b0; else s4 <= s0 & ~clr;
    always_ff @(negedge clk_p45 or negedge reset)
        if (!reset) s5 <= 1'b0; else s5 <= s0 & ~clr;
    always_ff @(negedge clk_p90 or negedge reset)
        if (!reset) s6 <= 1'b0; else s6 <= s0 & ~clr;
    always_ff @(negedge clk_p135 or negedge reset)
        if (!reset) s7 <= 1'b0; else s7 <= s0 & ~clr;

    assign q[SLOT_P0]   = s0;
    assign q[SLOT_P45]  = s1;
    assign q[SLOT_P90]  = s2;
    assign q[SLOT_P135] = s3;
    assign q[SLOT_N0]   = s4;
    assign q[SLOT_N45]  = s5;
    assign q[SLOT_N90]  = s6;
    assign q[SLOT_N135] = s7;
endmodule

// File: rtl/fine_gate_generator.sv
// fine_gate_generator: one gate pulse with both edges placed at 1/8-period resolution.
// Optional abort input enabled by defining FINE_GEN_ABORT_EN.
`timescale 1ns/1ps
module fine_gate_generator
    import fine_gate_generator_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          clk_p45,
    input  logic          clk_p90,
    input  logic          clk_p135,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] delay_coarse,
    input  logic [2:0]    delay_fine,
    input  logic [CW-1:0] width_coarse,
    input  logic [2:0]    width_fine,
`ifdef FINE_GEN_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic          gate_out
);
`ifndef FINE_GEN_ABORT_EN
    logic abort;
    assign abort = 1'b0;
`endif

    logic [1:0]    state;
    logic [CW-1:0] cnt, wc;
    logic [2:0]    fsel, gsel;
    logic          rise_arm, fall_arm, clr;
    logic [7:0]    rise_q, fall_q;

    function automatic logic [CW-1:0] wlast(input logic [CW-1:0] w);
        return (w == '0) ? '0 : w - 1'b1;
    endfunction

    // Arm edge k lands one period later on the slot-0 flop, so the rise arm is raised at S+D*T.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wc       <= '0;
            fsel     <= '0;
            gsel     <= '0;
            rise_arm <= 1'b0;
            fall_arm <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    busy <= 1'b1;
                    fsel <= delay_fine;
                    gsel <= width_fine;
                    wc   <= width_coarse;
                    if (delay_coarse == '0) begin
                        rise_arm <= 1'b1;
                        cnt      <= wlast(width_coarse);
                        state    <= HIGH;
                    end else begin
                        cnt   <= delay_coarse - 1'b1;
                        state <= DELAY;
                    end
                end
                DELAY, HIGH: begin
                    if (abort) begin
                        fall_arm <= 1'b1;
                        gsel     <= SLOT_P0;
                        cnt      <= CW'(FINISH_CYCLES - 1);
                        state    <= FINISH;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (state == DELAY) begin
                        rise_arm <= 1'b1;
                        cnt      <= wlast(wc);
                        state    <= HIGH;
                    end else begin
                        fall_arm <= 1'b1;
                        cnt      <= CW'(FINISH_CYCLES - 1);
                        state    <= FINISH;
                    end
                end
                default: begin
                    // Rise clears a period before fall so the unwinding slots never reopen the gate.
                    rise_arm <= 1'b0;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        fall_arm <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign clr = (state == IDLE) & ~done;

    fine_slot_capture u_rise (
        .clk      (clk),
        .clk_p45  (clk_p45),
        .clk_p90  (clk_p90),
        .clk_p135 (clk_p135),
        .reset    (reset),
        .clr      (clr),
        .arm      (rise_arm),
        .q        (rise_q)
    );

    fine_slot_capture u_fall (
        .clk      (clk),
        .clk_p45  (clk_p45),
        .clk_p90  (clk_p90),
        .clk_p135 (clk_p135),
        .reset    (reset),
        .clr      (clr),
        .arm      (fall_arm),
        .q        (fall_q)
    );

    assign gate_out = rise_q[fsel] & ~fall_q[gsel];
endmodule

// File: tb/tb_fine_gate_generator.sv
// tb_fine_gate_generator: measures gate edge and done times against the timing formulas
// (rise S+(D+1)T+f/8, fall S+(D+1+W)T+g/8, done S+(D+W+2)T) using a table, sweeps and random vectors.
`timescale 1ns/1ps
module tb_fine_gate_generator;
    localparam int CW = 32;

    logic clk = 1'b0, clk_p45 = 1'b0, clk_p90 = 1'b0, clk_p135 = 1'b0;
    logic reset = 1'b0, start = 1'b0;
    logic [CW-1:0] delay_coarse = '0, width_coarse = '0;
    logic [2:0] delay_fine = '0, width_fine = '0;
`ifdef FINE_GEN_ABORT_EN
    logic abort = 1'b0;
`endif
    logic busy, done, gate_out;

    int n_chk = 0, n_fail = 0;
    int n_rise = 0, n_fall = 0, n_done = 0;
    real t_rise = 0.0, t_fall = 0.0, t_done = 0.0;

    typedef struct {
        int d; int f; int w; int g;
        real rise; real fall; real fin;
    } vec_t;
    vec_t vecs[5];

    fine_gate_generator #(.CW(CW)) dut (
        .clk          (clk),
        .clk_p45      (clk_p45),
        .clk_p90      (clk_p90),
        .clk_p135     (clk_p135),
        .reset        (reset),
        .start        (start),
        .delay_coarse (delay_coarse),
        .delay_fine   (delay_fine),
        .width_coarse (width_coarse),
        .width_fine   (width_fine),
`ifdef FINE_GEN_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy),
        .done         (done),
        .gate_out     (gate_out)
    );

    initial forever #5 clk = ~clk;
    initial begin #1.25; forever #5 clk_p45 = ~clk_p45; end
    initial begin #2.5;  forever #5 clk_p90 = ~clk_p90; end
    initial begin #3.75; forever #5 clk_p135 = ~clk_p135; end

    always @(posedge gate_out) begin n_rise++; t_rise = $realtime; end
    always @(negedge gate_out) begin n_fall++; t_fall = $realtime; end
    always @(posedge done)     begin n_done++; t_done = $realtime; end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input real act, input real exp);
        n_chk++;
        if (act > exp + 0.01 || act < exp - 0.01) begin
            n_fail++;
            $display("FAIL %s: got %0.3f, expected %0.3f", name, act, exp);
        end
    endtask

    function automatic int wmin(input int w);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic kick(input int d, input int f, input int w, input int g, output real s);
        n_rise = 0; n_fall = 0; n_done = 0;
        @(posedge clk); #1;
        delay_coarse = d; delay_fine = 3'(f); width_coarse = w; width_fine = 3'(g);
        start = 1'b1;
        @(posedge clk); s = $realtime; #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit noise);
        int k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
            if (noise && !done) begin
                start = 1'($urandom_range(0, 1));
                delay_coarse = $urandom; width_coarse = $urandom;
                delay_fine = 3'($urandom); width_fine = 3'($urandom);
            end
        end
        start = 1'b0;
        chk({tag, " done seen"}, done, 1);
        chk({tag, " busy low at done"}, busy, 0);
    endtask

    task automatic run(input string tag, input int d, input int f, input int w, input int g,
                       input real erise, input real efall, input real efin, input bit noise);
        real s;
        kick(d, f, w, g, s);
        chk({tag, " busy after start"}, busy, 1);
        wait_done(tag, d + wmin(w) + 10, noise);
        chk({tag, " rise count"}, n_rise, 1);
        chk({tag, " fall count"}, n_fall, 1);
        chk({tag, " rise time"}, t_rise - s, erise);
        chk({tag, " fall time"}, t_fall - s, efall);
        chk({tag, " done time"}, t_done - s, efin);
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, done, 0);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " done count"}, n_done, 1);
    endtask

    task automatic run_model(input string tag, input int d, input int f, input int w, input int g,
                             input bit noise);
        run(tag, d, f, w, g, (d + 1) * 10.0 + f * 1.25,
            (d + 1 + wmin(w)) * 10.0 + g * 1.25, (d + wmin(w) + 2) * 10.0, noise);
    endtask

    initial begin
        real s;
        int k;
        vecs[0] = '{d:3, f:0, w:2, g:0, rise:40.0,  fall:60.0,  fin:70.0};
        vecs[1] = '{d:0, f:5, w:1, g:2, rise:16.25, fall:22.5,  fin:30.0};
        vecs[2] = '{d:0, f:7, w:0, g:0, rise:18.75, fall:20.0,  fin:30.0};
        vecs[3] = '{d:2, f:3, w:4, g:6, rise:33.75, fall:77.5,  fin:80.0};
        vecs[4] = '{d:1, f:6, w:3, g:1, rise:27.5,  fall:51.25, fin:60.0};

        #12;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset gate", gate_out, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++)
            run($sformatf("vec%0d", i), vecs[i].d, vecs[i].f, vecs[i].w, vecs[i].g,
                vecs[i].rise, vecs[i].fall, vecs[i].fin, 1'b0);

        for (int f = 0; f < 8; f++) begin
            run_model($sformatf("sweep f=%0d", f), 1, f, 1, f, 1'b0);
            chk($sformatf("sweep width f=%0d", f), t_fall - t_rise, 10.0);
        end

        for (int i = 0; i < 20; i++)
            run_model($sformatf("rand%0d", i), int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 12)), int'($urandom_range(0, 7)), 1'b0);

        for (int i = 0; i < 3; i++)
            run_model($sformatf("noise%0d", i), 2 + i, 2, 4, 5, 1'b1);

        kick(1, 0, 6, 0, s);
        k = 0;
        while (!gate_out && k < 20) begin @(posedge clk); #1; k++; end
        chk("pre-reset gate high", gate_out, 1);
        #3 reset = 1'b0;
        #0.5;
        chk("reset mid-high gate", gate_out, 0);
        chk("reset mid-high busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset mid-high no done", n_done, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        run_model("after reset", 2, 4, 2, 1, 1'b0);

`ifdef FINE_GEN_ABORT_EN
        begin
            real a;
            kick(5, 2, 2, 3, s);
            @(posedge clk); #1 abort = 1'b1;
            @(posedge clk); a = $realtime; #1 abort = 1'b0;
            wait_done("abort delay", 10, 1'b0);
            chk("abort delay no rise", n_rise, 0);
            chk("abort delay done time", t_done - a, 20.0);
            kick(0, 3, 6, 5, s);
            @(posedge clk); #1 abort = 1'b1;
            @(posedge clk); a = $realtime; #1 abort = 1'b0;
            wait_done("abort high", 10, 1'b0);
            chk("abort high rise count", n_rise, 1);
            chk("abort high fall time", t_fall - a, 10.0);
            chk("abort high done time", t_done - a, 20.0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
